// File: rtl/approx_pkg.sv
// Shared types, constants and the round-robin search used by the adder arbiter.
package approx_pkg;

  localparam int DATA_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  // Returns the first index with valid set, scanning ptr+1, ptr+2, ... modulo n.
  // Returns -1 when no requester is valid. Supports up to 8 requesters.
  function automatic int rr_next(input logic [7:0] valid, input int ptr, input int n);
    int idx;
    rr_next = -1;
    // Scan from farthest to nearest so the nearest valid index is kept last.
    for (int k = 8; k >= 1; k--) begin
      if (k <= n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (valid[idx[2:0]]) rr_next = idx;
      end
    end
  endfunction

endpackage

// File: rtl/approx_add16.sv
// Combinational 16-bit adder with a selectable approximate low part.
// In approximate mode the low APPROX_BITS bits never propagate a carry upward;
// a low bit is forced to 1 once any generate (a&b) appears at or above it.
module approx_add16
  import approx_pkg::*;
#(
  parameter int APPROX_BITS = 12
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              approx_en,
  output logic [DATA_W-1:0] sum
);

  localparam logic [DATA_W-1:0] HI_MASK = {DATA_W{1'b1}} << APPROX_BITS;

  logic [DATA_W-1:0] exact_sum;
  logic [DATA_W-1:0] approx_sum;
  logic              gen_seen;

  // Exact sum, plus approximate sum built from a carry-isolated upper part and
  // a generate-saturated lower part scanned from the top of the low field down.
  always_comb begin
    exact_sum  = a + b;
    approx_sum = ((a & HI_MASK) + (b & HI_MASK)) & HI_MASK;
    gen_seen   = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (i < APPROX_BITS) begin
        gen_seen      = gen_seen | (a[i] & b[i]);
        approx_sum[i] = gen_seen | a[i] | b[i];
      end
    end
    sum = approx_en ? approx_sum : exact_sum;
  end

endmodule

// File: rtl/approx_add_arbiter.sv
// Round-robin arbiter with burst locking sharing one approximate adder among
// NREQ requesters. Each accepted beat yields one registered, tagged result.
module approx_add_arbiter
  import approx_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int IDW         = 2,
  parameter int APPROX_BITS = 12,
  parameter int MAX_BURST   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     approx_en,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [DATA_W*NREQ-1:0]   req_a,
  input  logic [DATA_W*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]          req_last,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [DATA_W-1:0]        res_sum,
  output logic [IDW-1:0]           res_id,
  output logic                     res_last
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  state_e            state_q, state_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]    owner_q, owner_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

  logic              res_valid_q;
  logic [DATA_W-1:0] res_sum_q;
  logic [IDW-1:0]    res_id_q;
  logic              res_last_q;

  logic [7:0]        valid_ext;
  int                pick;
  logic [IDW-1:0]    gnt;
  logic              gnt_en;
  logic              slot_free;
  logic              xfer;
  logic              valid_sel;
  logic              last_sel;
  logic [DATA_W-1:0] op_a, op_b, sum;

  // Grant selection, ready generation and operand muxing for the current cycle.
  always_comb begin
    valid_ext             = '0;
    valid_ext[NREQ-1:0]   = req_valid;
    pick                  = rr_next(valid_ext, int'(rr_ptr_q), NREQ);
    gnt                   = '0;
    gnt_en                = 1'b0;
    if (state_q == LOCK) begin
      gnt    = owner_q;
      gnt_en = 1'b1;
    end else if (pick >= 0) begin
      gnt    = IDW'(pick);
      gnt_en = 1'b1;
    end
    slot_free = !res_valid_q || res_ready;
    req_ready = '0;
    valid_sel = 1'b0;
    last_sel  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == gnt) begin
        op_a      = req_a[DATA_W*i +: DATA_W];
        op_b      = req_b[DATA_W*i +: DATA_W];
        valid_sel = req_valid[i];
        last_sel  = req_last[i];
        req_ready[i] = gnt_en && slot_free && !rst;
      end
    end
    xfer = gnt_en && slot_free && valid_sel && !rst;
  end

  approx_add16 #(
    .APPROX_BITS(APPROX_BITS)
  ) u_add (
    .a         (op_a),
    .b         (op_b),
    .approx_en (approx_en),
    .sum       (sum)
  );

  // Next-state logic: burst lock entry, normal release and forced release.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    if (xfer) begin
      case (state_q)
        IDLE: begin
          if (last_sel) begin
            rr_ptr_d = gnt;
          end else begin
            state_d    = LOCK;
            owner_d    = gnt;
            beat_cnt_d = CNT_W'(1);
          end
        end
        LOCK: begin
          if (last_sel || beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
            state_d    = IDLE;
            rr_ptr_d   = owner_q;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= IDW'(NREQ - 1);
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Result register: loads on a transfer, drains when downstream accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_id_q    <= '0;
      res_last_q  <= 1'b0;
    end else if (xfer) begin
      res_valid_q <= 1'b1;
      res_sum_q   <= sum;
      res_id_q    <= gnt;
      res_last_q  <= last_sel;
    end else if (res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_id    = res_id_q;
  assign res_last  = res_last_q;

endmodule

// File: tb/tb_approx_add_arbiter.sv
// Randomized and directed bench for approx_add_arbiter against a behavioural model.
module tb_approx_add_arbiter;

  localparam int N  = 4;
  localparam int K  = 12;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            approx_en;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [16*N-1:0] req_a;
  logic [16*N-1:0] req_b;
  logic [N-1:0]    req_last;
  logic            res_valid;
  logic            res_ready;
  logic [15:0]     res_sum;
  logic [1:0]      res_id;
  logic            res_last;

  approx_add_arbiter #(
    .NREQ(N), .IDW(2), .APPROX_BITS(K), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst(rst), .approx_en(approx_en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_last(req_last),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_id(res_id), .res_last(res_last)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model state: lock owner, pointer of last grant, beats in current lock, output slot.
  bit          m_lock;
  int          m_owner, m_ptr, m_cnt;
  bit          m_rv;
  logic [15:0] m_sum;
  int          m_id;
  bit          m_last;
  int          m_g;
  bit          m_xfer;
  logic [N-1:0] m_ready;
  int          ids[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] ref_sum(input logic [15:0] a, input logic [15:0] b, input bit ap);
    logic [15:0] r;
    int hi;
    bit any;
    if (!ap || K == 0) return 16'((int'(a) + int'(b)) % 65536);
    hi = ((int'(a) >> K) + (int'(b) >> K)) % (1 << (16 - K));
    r  = 16'(hi << K);
    for (int i = 0; i < K; i++) begin
      any = 0;
      for (int j = i; j < K; j++) if (a[j] && b[j]) any = 1;
      r[i] = any ? 1'b1 : (a[i] | b[i]);
    end
    return r;
  endfunction

  function automatic void model_reset();
    m_lock = 0; m_owner = 0; m_ptr = N - 1; m_cnt = 0;
    m_rv = 0; m_sum = 0; m_id = 0; m_last = 0;
  endfunction

  // Who may send this cycle and whether a beat moves.
  function automatic void model_comb();
    int idx;
    m_g = -1;
    if (m_lock) m_g = m_owner;
    else
      for (int k = 1; k <= N; k++) begin
        idx = (m_ptr + k) % N;
        if (req_valid[idx] && m_g < 0) m_g = idx;
      end
    m_ready = '0;
    m_xfer  = 0;
    if (m_g >= 0 && (!m_rv || res_ready)) begin
      m_ready[m_g] = 1'b1;
      m_xfer       = req_valid[m_g];
    end
  endfunction

  function automatic void model_seq();
    bit lst;
    if (m_xfer) begin
      lst    = req_last[m_g];
      m_rv   = 1;
      m_sum  = ref_sum(req_a[16*m_g +: 16], req_b[16*m_g +: 16], approx_en);
      m_id   = m_g;
      m_last = lst;
      if (!m_lock) begin
        if (lst) m_ptr = m_g;
        else begin m_lock = 1; m_owner = m_g; m_cnt = 1; end
      end else if (lst || m_cnt == MB - 1) begin
        m_lock = 0; m_ptr = m_owner; m_cnt = 0;
      end else m_cnt++;
    end else if (res_ready) m_rv = 0;
  endfunction

  // One clock: inputs already driven after a negedge.
  task automatic cycle();
    #1;
    model_comb();
    check("req_ready", 32'(req_ready), 32'(m_ready));
    @(posedge clk);
    model_seq();
    @(negedge clk);
    check("res_valid", 32'(res_valid), 32'(m_rv));
    if (m_rv) begin
      check("res_sum",  32'(res_sum),  32'(m_sum));
      check("res_id",   32'(res_id),   32'(m_id));
      check("res_last", 32'(res_last), 32'(m_last));
      ids.push_back(int'(res_id));
    end
  endtask

  task automatic drive_idle();
    req_valid = '0; req_last = '0; req_a = '0; req_b = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic single(input logic [15:0] a, input logic [15:0] b, input bit ap, input logic [15:0] exp);
    approx_en = ap; req_valid = 4'b0001; req_last = 4'b0001;
    req_a[15:0] = a; req_b[15:0] = b;
    cycle();
    check("arith_const", 32'(res_sum), 32'(exp));
    check("arith_id", 32'(res_id), 32'd0);
  endtask

  logic [15:0] held_sum;
  logic [1:0]  held_id;

  initial begin
    rst = 1'b1; approx_en = 1'b1; res_ready = 1'b1;
    drive_idle();
    req_valid = '1;
    #2;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_sum",   32'(res_sum),   32'd0);
    check("rst_id",    32'(res_id),    32'd0);
    check("rst_last",  32'(res_last),  32'd0);
    do_reset();

    // Arithmetic vectors.
    single(16'h1003, 16'h2005, 1'b1, 16'h3007);
    check("arith_last", 32'(res_last), 32'd1);
    single(16'h0800, 16'h0800, 1'b1, 16'h0FFF);
    single(16'hF000, 16'h1000, 1'b1, 16'h0000);
    single(16'h1003, 16'h2005, 1'b0, 16'h3008);
    single(16'h0800, 16'h0800, 1'b0, 16'h1000);
    single(16'hF000, 16'h1000, 1'b0, 16'h0000);

    // Round-robin fairness with all requesters streaming single beats.
    do_reset();
    ids.delete();
    req_valid = '1; req_last = '1;
    for (int c = 0; c < 8; c++) begin
      req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
      cycle();
    end
    check("rr_count", 32'(ids.size()), 32'd8);
    for (int i = 0; i < ids.size(); i++) check("rr_order", 32'(ids[i]), 32'(i % N));

    // Burst lock from requester 2 while requester 1 waits.
    do_reset();
    ids.delete();
    req_valid = 4'b0100; req_last = 4'b0000;
    cycle();
    req_valid = 4'b0110;
    cycle();
    req_last = 4'b0110;
    cycle();
    req_valid = 4'b0010;
    cycle();
    check("burst_len", 32'(ids.size()), 32'd4);
    if (ids.size() == 4)
      for (int i = 0; i < 4; i++) check("burst_id", 32'(ids[i]), (i < 3) ? 32'd2 : 32'd1);

    // Forced release after MB beats.
    do_reset();
    ids.delete();
    req_valid = 4'b1001; req_last = 4'b1000;
    for (int c = 0; c < 10; c++) cycle();
    check("force_len", 32'(ids.size()), 32'd10);
    if (ids.size() == 10)
      for (int i = 0; i < 10; i++) check("force_id", 32'(ids[i]), (i % 5 == 4) ? 32'd3 : 32'd0);

    // Backpressure: result held, nothing accepted.
    do_reset();
    req_valid = 4'b0011; req_last = 4'b0011;
    req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
    cycle();
    held_sum = res_sum; held_id = res_id;
    res_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      check("bp_hold_sum", 32'(res_sum), 32'(held_sum));
      check("bp_hold_id",  32'(res_id),  32'(held_id));
    end
    res_ready = 1'b1;
    cycle();
    cycle();

    // Asynchronous reset in the middle of a lock.
    do_reset();
    req_valid = 4'b0100; req_last = 4'b0000;
    cycle();
    cycle();
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_sum",   32'(res_sum),   32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    req_valid = '1; req_last = '1;
    cycle();
    check("mid_rst_first", 32'(res_id), 32'd0);
    cycle();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      approx_en = 1'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      req_valid = 4'($urandom);
      req_last  = 4'($urandom);
      req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
